count_ctrl: RTL and testbench

COUNT_CTRL -- requirements
Module: count_ctrl

---
 rtl/count_pkg.sv | 25 ++
 rtl/count_core.sv | 39 +++
 rtl/count_ctrl.sv | 113 +++++++++++
 tb/tb_count_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// count_pkg: shared definitions for the count_ctrl block.
// Holds the command encoding, the controller state encoding and the
// terminal value loaded into the limit register at reset.
package count_pkg;

    // Terminal value loaded into the limit register at reset.
    localparam int DEFAULT_LIMIT = 23;

    // Command opcodes presented on cmd_op.
    typedef enum logic [1:0] {
        OP_NOP        = 2'b00,
        OP_START      = 2'b01,
        OP_STOP       = 2'b10,
        OP_LOAD_LIMIT = 2'b11
    } cmd_op_e;

    // Controller states: IDLE (count 0, stopped), RUN (counting),
    // PAUSE (stopped, count held).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

endpackage

// File: rtl/count_core.sv
// count_core: the counting register of count_ctrl.
// Counts up to 'limit' and wraps to 0, raising 'wrap' for the one cycle
// that follows the limit-to-0 step. 'clear' forces the count to 0 without
// a wrap and takes priority over 'enable'. Reset is synchronous, active-low.
module count_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] number,
    output logic             wrap
);

    // Count register and wrap flag: clear beats enable; wrap marks limit-to-0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            number <= '0;
            wrap   <= 1'b0;
        end else if (clear) begin
            number <= '0;
            wrap   <= 1'b0;
        end else if (enable) begin
            if (number == limit) begin
                number <= '0;
                wrap   <= 1'b1;
            end else begin
                number <= number + WIDTH'(1);
                wrap   <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: command-driven up-counter with IDLE/RUN/PAUSE control.
// Commands (NOP, START, STOP, LOAD_LIMIT) are accepted on cmd_valid &&
// cmd_ready; a limit load is refused while running. The counting register
// lives in count_core; this module holds the FSM, the limit register and
// the handshake. Reset is synchronous and active-low on 'rst'.
// Optional feature: define COUNT_CTRL_WRAPCNT_EN to add an 8-bit saturating
// wrap_count output, cleared by reset and by STOP into IDLE.
module count_ctrl #(
    parameter int WIDTH         = 8,
    parameter int DEFAULT_LIMIT = count_pkg::DEFAULT_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] number,
    output logic             running,
    output logic             wrap
`ifdef COUNT_CTRL_WRAPCNT_EN
    ,
    output logic [7:0]       wrap_count
`endif
);

    import count_pkg::*;

    state_e           state;
    logic [WIDTH-1:0] limit;
    cmd_op_e          op;
    logic             accept;
    logic             core_clear;
    logic             core_enable;

    assign op = cmd_op_e'(cmd_op);

    // Handshake and counter control derived from the current state and command.
    always_comb begin
        // NOTE: each signal gets a default first so no latch is inferred.
        cmd_ready   = !((state == ST_RUN) && (op == OP_LOAD_LIMIT));
        accept      = cmd_valid && cmd_ready;
        // Count on every RUN edge except the one where a STOP is taken.
        core_enable = (state == ST_RUN) && !(accept && (op == OP_STOP));
        core_clear  = 1'b0;
        if (accept && (state == ST_PAUSE)) begin
            if (op == OP_STOP) begin
                core_clear = 1'b1;
            end else if ((op == OP_START) && (number > limit)) begin
                // A lowered limit would leave the held count out of range.
                core_clear = 1'b1;
            end
        end
    end

    // Controller FSM with registered running flag and the limit register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            limit   <= WIDTH'(DEFAULT_LIMIT);
        end else if (accept) begin
            case (op)
                OP_START: begin
                    if (state != ST_RUN) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                OP_STOP: begin
                    if (state == ST_RUN) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end else if (state == ST_PAUSE) begin
                        state <= ST_IDLE;
                    end
                end
                OP_LOAD_LIMIT: begin
                    // Only reachable outside RUN, since cmd_ready is low there.
                    limit <= cmd_data;
                end
                default: begin
                end
            endcase
        end
    end

    count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .clear  (core_clear),
        .enable (core_enable),
        .limit  (limit),
        .number (number),
        .wrap   (wrap)
    );

`ifdef COUNT_CTRL_WRAPCNT_EN
    // Saturating count of wrap pulses; cleared by reset and by STOP into IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap_count <= '0;
        end else if (accept && (op == OP_STOP) && (state == ST_PAUSE)) begin
            wrap_count <= '0;
        end else if (wrap && (wrap_count != 8'hFF)) begin
            wrap_count <= wrap_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: scoreboard bench for count_ctrl.
// Each stimulus step updates a behavioural model and queues the expected
// cmd_ready and post-edge outputs; independent monitor processes pop and
// compare them. Directed sequences cover the key scenarios, then random
// commands and resets run against the same model.
module tb_count_ctrl;

    localparam int W           = 8;
    localparam int RESET_LIMIT = 23;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op    = 2'b00;
    logic [W-1:0] cmd_data  = '0;
    logic [W-1:0] number;
    logic         running;
    logic         wrap;
`ifdef COUNT_CTRL_WRAPCNT_EN
    logic [7:0]   wrap_count;
`endif

    int checks = 0;
    int errors = 0;

    count_ctrl #(
        .WIDTH         (W),
        .DEFAULT_LIMIT (RESET_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .number    (number),
        .running   (running),
        .wrap      (wrap)
`ifdef COUNT_CTRL_WRAPCNT_EN
        ,
        .wrap_count(wrap_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_e;
    typedef struct {
        int num;
        bit run;
        bit wrp;
        int wc;
    } exp_t;

    exp_t  q_out[$];
    bit    q_rdy[$];
    mode_e m_mode  = M_IDLE;
    int    m_num   = 0;
    int    m_limit = RESET_LIMIT;
    int    m_wc    = 0;
    bit    m_wrap  = 1'b0;
    bit    m_known = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model and queue expectations.
    // Called at posedge+2; returns at the next posedge+2.
    task automatic step(input bit r, input bit v, input logic [1:0] op, input int d);
        bit rdy;
        bit acc;
        bit adv;
        int nxt;
        exp_t e;
        rst       = r;
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = W'(d);
        rdy = !(m_mode == M_RUN && op == OP_LOAD);
        if (m_known) q_rdy.push_back(rdy);
        acc = v && rdy;
        if (!r) begin
            m_mode  = M_IDLE;
            m_num   = 0;
            m_limit = RESET_LIMIT;
            m_wrap  = 1'b0;
            m_wc    = 0;
            m_known = 1'b1;
        end else begin
            if (m_wrap && m_wc < 255) m_wc++;
            adv    = (m_mode == M_RUN) && !(acc && op == OP_STOP);
            m_wrap = 1'b0;
            if (adv) begin
                nxt    = (m_num + 1) % (m_limit + 1);
                m_wrap = (nxt == 0);
                m_num  = nxt;
            end
            if (acc) begin
                case (op)
                    OP_START: if (m_mode != M_RUN) begin
                        if (m_num > m_limit) m_num = 0;
                        m_mode = M_RUN;
                    end
                    OP_STOP: if (m_mode == M_RUN) begin
                        m_mode = M_PAUSE;
                    end else if (m_mode == M_PAUSE) begin
                        m_mode = M_IDLE;
                        m_num  = 0;
                        m_wc   = 0;
                    end
                    OP_LOAD: m_limit = d;
                    default: ;
                endcase
            end
        end
        e.num = m_num;
        e.run = (m_mode == M_RUN);
        e.wrp = m_wrap;
        e.wc  = m_wc;
        q_out.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic cmd(input logic [1:0] op, input int d);
        step(1'b1, 1'b1, op, d);
    endtask

    task automatic nops(input int n);
        repeat (n) step(1'b1, 1'b1, OP_NOP, 0);
    endtask

    // Output monitor: compares registered outputs just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_out.size() > 0) begin
                exp_t e;
                e = q_out.pop_front();
                check("sb_number", 32'(number), 32'(e.num));
                check("sb_running", 32'(running), 32'(e.run));
                check("sb_wrap", 32'(wrap), 32'(e.wrp));
`ifdef COUNT_CTRL_WRAPCNT_EN
                check("sb_wrap_count", 32'(wrap_count), 32'(e.wc));
`endif
            end
        end
    end

    // Handshake monitor: compares cmd_ready mid-cycle for the driven command.
    initial begin
        forever begin
            @(negedge clk);
            if (q_rdy.size() > 0) check("sb_cmd_ready", 32'(cmd_ready), 32'(q_rdy.pop_front()));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int max_seen;
        int first_wrap;
        int second_wrap;

        rst = 1'b0;
        @(posedge clk);
        #2;

        // Reset with commands present: they must be discarded.
        step(1'b0, 1'b1, OP_START, 0);
        step(1'b0, 1'b1, OP_LOAD, 3);
        check("reset_number", 32'(number), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);
        check("reset_ready", 32'(cmd_ready), 32'd1);

        // Count 0..23 then wrap with the default limit.
        cmd(OP_START, 0);
        check("start_running", 32'(running), 32'd1);
        check("start_number", 32'(number), 32'd0);
        nops(23);
        check("count_at_23", 32'(number), 32'd23);
        check("no_wrap_at_23", 32'(wrap), 32'd0);
        nops(1);
        check("wrap_to_0", 32'(number), 32'd0);
        check("wrap_pulse", 32'(wrap), 32'd1);
        nops(1);
        check("after_wrap", 32'(number), 32'd1);
        check("wrap_one_cycle", 32'(wrap), 32'd0);

        // Limit 5: wrap period 6, never above 5.
        cmd(OP_STOP, 0);
        cmd(OP_STOP, 0);
        cmd(OP_LOAD, 5);
        cmd(OP_START, 0);
        max_seen    = 0;
        first_wrap  = -1;
        second_wrap = -1;
        for (int i = 0; i < 18; i++) begin
            nops(1);
            if (int'(number) > max_seen) max_seen = int'(number);
            if (wrap === 1'b1) begin
                if (first_wrap < 0) first_wrap = i;
                else if (second_wrap < 0) second_wrap = i;
            end
        end
        check("limit5_max", 32'(max_seen), 32'd5);
        check("limit5_period", 32'(second_wrap - first_wrap), 32'd6);

        // STOP at 10 holds; second STOP clears.
        cmd(OP_STOP, 0);
        cmd(OP_STOP, 0);
        cmd(OP_LOAD, 23);
        cmd(OP_START, 0);
        nops(10);
        check("run_to_10", 32'(number), 32'd10);
        cmd(OP_STOP, 0);
        check("pause_hold", 32'(number), 32'd10);
        check("pause_running", 32'(running), 32'd0);
        nops(1);
        check("pause_hold2", 32'(number), 32'd10);
        cmd(OP_STOP, 0);
        check("idle_clear", 32'(number), 32'd0);
        check("idle_running", 32'(running), 32'd0);

        // LOAD refused in RUN, accepted in PAUSE.
        cmd(OP_START, 0);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 8'd7;
        #1;
        check("load_run_ready", 32'(cmd_ready), 32'd0);
        repeat (3) cmd(OP_LOAD, 7);
        check("load_run_counting", 32'(number), 32'd3);
        cmd(OP_STOP, 0);
        cmd(OP_LOAD, 7);
        cmd(OP_START, 0);
        nops(4);
        check("limit7_top", 32'(number), 32'd7);
        check("limit7_nowrap", 32'(wrap), 32'd0);
        nops(1);
        check("limit7_wrap", 32'(wrap), 32'd1);

        // Reset mid-RUN at 15; default limit restored.
        cmd(OP_STOP, 0);
        cmd(OP_STOP, 0);
        cmd(OP_LOAD, 5);
        cmd(OP_LOAD, 20);
        cmd(OP_START, 0);
        nops(15);
        check("pre_reset_15", 32'(number), 32'd15);
        step(1'b0, 1'b1, OP_START, 0);
        check("midrun_reset_number", 32'(number), 32'd0);
        check("midrun_reset_running", 32'(running), 32'd0);
        check("midrun_reset_wrap", 32'(wrap), 32'd0);
        cmd(OP_START, 0);
        nops(23);
        check("post_reset_23", 32'(number), 32'd23);
        nops(1);
        check("post_reset_wrap", 32'(wrap), 32'd1);

        // START from PAUSE with count above a lowered limit clears silently.
        nops(10);
        cmd(OP_STOP, 0);
        cmd(OP_LOAD, 4);
        cmd(OP_START, 0);
        check("restart_clear", 32'(number), 32'd0);
        check("restart_nowrap", 32'(wrap), 32'd0);
        check("restart_running", 32'(running), 32'd1);

        // STOP on the limit edge wins: hold at limit, no wrap.
        nops(4);
        check("at_limit4", 32'(number), 32'd4);
        cmd(OP_STOP, 0);
        check("stop_at_limit_hold", 32'(number), 32'd4);
        check("stop_at_limit_nowrap", 32'(wrap), 32'd0);
        cmd(OP_START, 0);
        nops(1);
        check("resume_wrap", 32'(wrap), 32'd1);

        // Limit 0: stays 0, wraps every cycle.
        cmd(OP_STOP, 0);
        cmd(OP_STOP, 0);
        cmd(OP_LOAD, 0);
        cmd(OP_START, 0);
        check("limit0_first", 32'(wrap), 32'd0);
        for (int i = 0; i < 3; i++) begin
            nops(1);
            check("limit0_number", 32'(number), 32'd0);
            check("limit0_wrap", 32'(wrap), 32'd1);
        end

        // Wrap counter with limit 2.
        cmd(OP_STOP, 0);
        cmd(OP_STOP, 0);
        cmd(OP_LOAD, 2);
        cmd(OP_START, 0);
        nops(9);
        check("limit2_third_wrap", 32'(wrap), 32'd1);
        nops(1);
`ifdef COUNT_CTRL_WRAPCNT_EN
        check("wrap_count_3", 32'(wrap_count), 32'd3);
`endif
        cmd(OP_STOP, 0);
        cmd(OP_STOP, 0);
`ifdef COUNT_CTRL_WRAPCNT_EN
        check("wrap_count_clear", 32'(wrap_count), 32'd0);
`endif

        // Maximum limit 255.
        cmd(OP_LOAD, 255);
        cmd(OP_START, 0);
        nops(255);
        check("limit255_top", 32'(number), 32'd255);
        nops(1);
        check("limit255_wrap", 32'(wrap), 32'd1);
        check("limit255_zero", 32'(number), 32'd0);

        // Random commands and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int   x;
            int   d;
            bit   r;
            bit   v;
            logic [1:0] op;
            r = ($urandom_range(0, 99) >= 2);
            v = ($urandom_range(0, 4) != 0);
            x = int'($urandom_range(0, 15));
            op = (x < 8) ? OP_NOP : (x < 11) ? OP_START : (x < 13) ? OP_STOP : OP_LOAD;
            d = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 255));
            step(r, v, op, d);
        end

        check("sb_drain", 32'(q_out.size() + q_rdy.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
